// File: rtl/hex_display_pkg.sv
// Shared constants and types for the multi-digit seven-segment display controller.
// Segment codes are active-low, bit order g..a (bit 6 = g).
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    IDLE   = 1'b0,
    DECODE = 1'b1
  } state_t;

endpackage

// File: rtl/hex_digit_decode.sv
// Single shared nibble-to-segment lookup; the controller time-multiplexes it
// across digits instead of instantiating one decoder per digit.
module hex_digit_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit HEX display controller: decodes one digit per cycle into a shadow
// frame, commits the whole frame at once, then applies per-digit blink gating.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_value,
  input  logic                   lz_en,
  input  logic [NDIGITS-1:0]     blink_mask,
  output logic [7*NDIGITS-1:0]   hex_out
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);

  state_t state, state_next;
  logic   transfer;
  logic   last_digit;

  logic [IDX_W-1:0]     idx;
  logic [4*NDIGITS-1:0] value_q;
  logic                 lz_q;
  logic [NDIGITS-1:0]   mask_q;
  logic [NDIGITS-1:0]   active_mask;

  logic [NDIGITS-1:0]   lz_blank;
  logic [3:0]           cur_nibble;
  logic                 cur_blank;
  logic [6:0]           cur_seg;

  logic [7*NDIGITS-1:0] shadow;
  logic [7*NDIGITS-1:0] shadow_next;
  logic [7*NDIGITS-1:0] frame;

  logic [CNT_W-1:0]     prescaler;
  logic                 blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    transfer   = 1'b0;
    last_digit = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          transfer   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (idx == LAST_IDX) begin
          last_digit = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      lz_q    <= 1'b0;
      mask_q  <= '0;
    end else if (transfer) begin
      value_q <= load_value;
      lz_q    <= lz_en;
      mask_q  <= blink_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (transfer || last_digit) begin
      idx <= '0;
    end else if (state == DECODE) begin
      idx <= idx + 1'b1;
    end
  end

  // Walk from the top digit down: a digit is blanked only while everything
  // above it (and itself) is zero; digit 0 always shows.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (value_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_q && (i != 0) && upper_zero;
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = value_q[4*i +: 4];
        cur_blank  = lz_blank[i];
      end
    end
  end

  hex_digit_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        shadow_next[7*i +: 7] = cur_blank ? SEG_BLANK : cur_seg;
      end
    end
  end

  // The committed frame takes shadow_next so the last digit lands in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= {NDIGITS{SEG_BLANK}};
      frame       <= {NDIGITS{SEG_BLANK}};
      active_mask <= '0;
    end else if (state == DECODE) begin
      shadow <= shadow_next;
      if (last_digit) begin
        frame       <= shadow_next;
        active_mask <= mask_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      blink_phase <= 1'b0;
    end else if (prescaler == CNT_MAX) begin
      prescaler   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    hex_out = frame;
    for (int i = 0; i < NDIGITS; i++) begin
      if (blink_phase && active_mask[i]) begin
        hex_out[7*i +: 7] = SEG_BLANK;
      end
    end
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit seven-segment display controller for the board HEX outputs. It accepts a packed hex value through a valid/ready handshake and decodes it one digit per cycle into a shadow register. The complete frame is then committed to the segment outputs in one step, with optional leading-zero blanking and per-digit blinking. It sits between the decrypter datapath/status logic and the HEX pins, and replaces per-digit combinational decoders.

## Interface
- NDIGITS, 6: number of digits driven; must be 1..8.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period; must be ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  request to display a new value.
- load_ready  out  1  high when a load can be accepted.
- load_value  in  4*NDIGITS  packed nibbles; digit i = load_value[4i+3:4i]; digit 0 is least significant.
- lz_en  in  1  leading-zero blanking for this load.
- blink_mask  in  NDIGITS  bit i set = digit i blinks for this load.
- hex_out  out  7*NDIGITS  active-low segments; digit i = hex_out[7i+6:7i], bit order g..a (bit 6 = g).

## Operation
- Handshake: a transfer occurs on a rising edge where load_valid && load_ready. load_value, lz_en and blink_mask are latched on that edge. load_valid while load_ready=0 is ignored; no queuing.
- FSM IDLE: load_ready=1. On transfer, latch inputs, set idx=0, go to DECODE.
- FSM DECODE: load_ready=0. Each edge writes shadow[idx] = decoded nibble idx, or 7'b1111111 if blanked, then idx++. On the edge with idx==NDIGITS-1:
  - write the last shadow digit;
  - copy the full shadow (including that digit) to the hex_out register;
  - copy the latched blink_mask to the active mask;
  - go to IDLE.
- hex_out never shows a mix of old and new digits.
- Decode encoding (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking: when lz_en=1, digit i (i≥1) is blanked iff nibbles i..NDIGITS-1 of the latched value are all zero. Digit 0 is never lz-blanked, so value 0 shows a single "0".
- Blink: a free-running prescaler counts 0..BLINK_DIV-1 and wraps. On wrap, blink_phase toggles. While blink_phase=1, each digit with its active mask bit set drives 7'b1111111. Otherwise it drives the committed segments.
- The prescaler is not reset or affected by loads.
- Blink gating is a combinational AND over the registered frame and mask; no extra latency.

## Timing
- Reset (async, rst_n=0), effective immediately:
  - hex_out = all ones (blank);
  - load_ready = 1; state IDLE; idx = 0;
  - shadow and committed frame = all ones; active mask = 0;
  - prescaler = 0; blink_phase = 0.
- Reset during DECODE aborts the load. The display stays blank until a new load completes.
- Latency: transfer on edge E0; new frame visible on hex_out after edge E_NDIGITS. load_ready returns high after that same edge.
- Earliest next transfer is at edge E_NDIGITS+1. Maximum throughput is one load per NDIGITS+1 cycles.
- NDIGITS=1: DECODE lasts one edge (idx 0 is also the last).
- Blink phase boundary: when the counter equals BLINK_DIV-1, the next edge sets the counter to 0 and toggles the phase.
- A commit and a phase toggle on the same edge are both applied. Output after that edge reflects the new frame under the new phase.

## Structure
- Package hex_display_pkg holds:
  - the 16-entry seg encoding constant array;
  - the blank constant 7'b1111111;
  - the FSM state enum (IDLE, DECODE).
- Sub-module hex_digit_decode: combinational 4-bit to 7-bit lookup using the package array. Instantiate one copy, muxed by idx; do not instantiate NDIGITS copies.
- Top holds the FSM, idx counter, latched inputs, shadow and committed frame registers, blink prescaler and output gating.

## Test plan
- Reset: assert rst_n=0 mid-DECODE -> hex_out all ones and load_ready=1 immediately. After release, with no load, hex_out stays all ones.
- Basic load, NDIGITS=6: load 24'h0A3F19, lz_en=0, mask=0 -> load_ready low for exactly 6 cycles. hex_out stays at its old value until edge E6, then shows digits 9,1,F,3,A,0 (digit 0..5) with the correct codes in a single update.
- Leading zeros: load 24'h000042 with lz_en=1 -> digits 2..5 = 1111111, digit1=0011001, digit0=0100100. Then load 24'h0 with lz_en=1 -> only digit0 = 1000000.
- Back-pressure: hold load_valid high with changing load_value during DECODE -> only the first value is displayed. The second transfer happens at edge E7 with the value present then.
- Blink, BLINK_DIV=4: mask=6'b000001 -> digit0 alternates code/blank every 4 cycles. Other digits are steady, and the phase is unaffected by a load issued mid-period.
- Parameter sweep: NDIGITS=1 and 8 -> latency equals NDIGITS, and all 16 nibble codes appear correctly on every digit position.
